// File: rtl/xf_pkg.sv
// Shared constants for the transformer datapath blocks that talk to the FLOAT16 multiplier wrapper.
package xf_pkg;

    localparam int FP16_W         = 16;
    localparam int MUL_INFO_IN_W  = 23;
    localparam int MUL_INFO_OUT_W = 24;

    // info_in is {id, user}: id sits in the top bits, user starts at bit 0
    localparam int INFO_ID_MSB    = MUL_INFO_IN_W - 1;
    localparam int INFO_USER_LSB  = 0;

    localparam int CNT_W          = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic          found_s;
    logic [IW-1:0] cand_s;

    // Scan from ptr upward; N is a power of two so the IW-bit sum wraps for free
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = ptr;
        for (int k = 0; k < N; k++) begin
            cand_s = ptr + IW'(k);
            if (!found_s && req[cand_s]) begin
                found_s     = 1'b1;
                gnt[cand_s] = 1'b1;
                idx         = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mul_arb.sv
// Round-robin arbiter sharing one registered FLOAT16 multiplier among NREQ requesters,
// with locked bursts, ID tagging through the info field and product routing back to the owner.
module mul_arb
    import xf_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int USER_W = 21
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_vld,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*FP16_W-1:0]   req_data0,
    input  logic [NREQ*FP16_W-1:0]   req_data1,
    input  logic [NREQ*USER_W-1:0]   req_info,
    output logic [NREQ-1:0]          req_rdy,
    output logic                     mul_vld_in,
    output logic [MUL_INFO_IN_W-1:0] mul_info_in,
    output logic [FP16_W-1:0]        mul_data0,
    output logic [FP16_W-1:0]        mul_data1,
    input  logic                     mul_vld_out,
    input  logic [MUL_INFO_OUT_W-1:0] mul_info_out,
    input  logic [FP16_W-1:0]        mul_result,
    output logic [NREQ-1:0]          rsp_vld,
    output logic [USER_W-1:0]        rsp_info,
    output logic [FP16_W-1:0]        rsp_data,
    output logic                     busy
);

    arb_state_e               state_q, state_d;
    logic [IDW-1:0]           ptr_q, ptr_d;
    logic [IDW-1:0]           owner_q, owner_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     mul_vld_in_q, mul_vld_in_d;
    logic [MUL_INFO_IN_W-1:0] mul_info_in_q, mul_info_in_d;
    logic [FP16_W-1:0]        mul_data0_q, mul_data0_d;
    logic [FP16_W-1:0]        mul_data1_q, mul_data1_d;
    logic [NREQ-1:0]          rsp_vld_q, rsp_vld_d;
    logic [USER_W-1:0]        rsp_info_q, rsp_info_d;
    logic [FP16_W-1:0]        rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]          pick_gnt_s;
    logic [IDW-1:0]           pick_idx_s;
    logic [NREQ-1:0]          lock_gnt_s;
    logic [NREQ-1:0]          rdy_s;
    logic [IDW-1:0]           win_idx_s;
    logic                     accept_s;
    logic                     win_last_s;
    logic [FP16_W-1:0]        sel_data0_s;
    logic [FP16_W-1:0]        sel_data1_s;
    logic [USER_W-1:0]        sel_info_s;
    logic [IDW-1:0]           rsp_id_s;
    logic                     unused_ext_s;

    rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_rr_pick (
        .req (req_vld),
        .ptr (ptr_q),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s)
    );

    // Grant: rotating pick while idle, owner-only while a burst is locked
    always_comb begin
        lock_gnt_s          = '0;
        lock_gnt_s[owner_q] = req_vld[owner_q];
        if (!rst_n) begin
            rdy_s = '0;
        end else if (state_q == ST_LOCK) begin
            rdy_s = lock_gnt_s;
        end else begin
            rdy_s = pick_gnt_s;
        end
        win_idx_s = (state_q == ST_LOCK) ? owner_q : pick_idx_s;
        accept_s  = |rdy_s;
    end

    // Operand/tag mux for the winning requester
    always_comb begin
        sel_data0_s = '0;
        sel_data1_s = '0;
        sel_info_s  = '0;
        win_last_s  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx_s == IDW'(i)) begin
                sel_data0_s = req_data0[i*FP16_W +: FP16_W];
                sel_data1_s = req_data1[i*FP16_W +: FP16_W];
                sel_info_s  = req_info[i*USER_W +: USER_W];
                win_last_s  = req_last[i];
            end else begin
                win_last_s  = win_last_s;
            end
        end
    end

    // Arbitration state, pointer and burst owner
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && win_last_s) begin
                    ptr_d = win_idx_s + IDW'(1);
                end else if (accept_s) begin
                    owner_d = win_idx_s;
                    state_d = ST_LOCK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (accept_s && win_last_s) begin
                    ptr_d   = owner_q + IDW'(1);
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // In-flight count; a simultaneous issue and return cancel out
    always_comb begin
        case ({accept_s, mul_vld_out})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Issue register: operands and tag hold when nothing is accepted
    always_comb begin
        mul_info_in_d = mul_info_in_q;
        mul_data0_d   = mul_data0_q;
        mul_data1_d   = mul_data1_q;
        if (accept_s) begin
            mul_vld_in_d  = 1'b1;
            mul_info_in_d = {win_idx_s, sel_info_s};
            mul_data0_d   = sel_data0_s;
            mul_data1_d   = sel_data1_s;
        end else begin
            mul_vld_in_d  = 1'b0;
        end
    end

    assign rsp_id_s     = mul_info_out[INFO_ID_MSB -: IDW];
    assign unused_ext_s = mul_info_out[MUL_INFO_OUT_W-1];

    // Response routing by the id the multiplier echoed back
    always_comb begin
        rsp_vld_d  = '0;
        rsp_info_d = rsp_info_q;
        rsp_data_d = rsp_data_q;
        if (mul_vld_out) begin
            rsp_vld_d[rsp_id_s] = 1'b1;
            rsp_info_d          = mul_info_out[USER_W-1:INFO_USER_LSB];
            rsp_data_d          = mul_result;
        end else begin
            rsp_vld_d = '0;
        end
    end

    // All state, issue and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            cnt_q         <= '0;
            mul_vld_in_q  <= 1'b0;
            mul_info_in_q <= '0;
            mul_data0_q   <= '0;
            mul_data1_q   <= '0;
            rsp_vld_q     <= '0;
            rsp_info_q    <= '0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            mul_vld_in_q  <= mul_vld_in_d;
            mul_info_in_q <= mul_info_in_d;
            mul_data0_q   <= mul_data0_d;
            mul_data1_q   <= mul_data1_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_info_q    <= rsp_info_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    assign req_rdy     = rdy_s;
    assign mul_vld_in  = mul_vld_in_q;
    assign mul_info_in = mul_info_in_q;
    assign mul_data0   = mul_data0_q;
    assign mul_data1   = mul_data1_q;
    assign rsp_vld     = rsp_vld_q;
    assign rsp_info    = rsp_info_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = (cnt_q != '0) | (state_q == ST_LOCK);

endmodule

// File: doc/mul_arb.md
# mul_arb

Round-robin arbiter that shares one FLOAT16 multiplier stage (the `MUL` wrapper around `FLOAT16_MUL`: 1-cycle registered latency, `vld_in`/`info_in[22:0]` in, `vld_out`/`info_out[23:0]`/`mul` out) between `NREQ` transformer datapath requesters.

- Accepts operand pairs with a valid/ready handshake.
- Supports locked bursts so a requester can stream a dependent sequence back-to-back, for example Taylor terms.
- Tags each operation with the requester ID carried in the multiplier's info field.
- Routes the returning product back to the owning requester.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; must be a power of 2, 2..8.
- `IDW`, 2: requester ID width, equal to log2(`NREQ`).
- `USER_W`, 21: per-op user info width, equal to 23 − `IDW`.

Ports:
- `clk`  in  1  single clock. All logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_vld`  in  `NREQ`  per-requester operand valid.
- `req_last`  in  `NREQ`  beat ends the burst. A value of 1 on a single op means no lock.
- `req_data0`  in  `NREQ`×16  FP16 operand A, packed, requester i at [16i+15:16i].
- `req_data1`  in  `NREQ`×16  FP16 operand B, packed.
- `req_info`  in  `NREQ`×`USER_W`  user tag, packed.
- `req_rdy`  out  `NREQ`  one-hot or zero. Combinational grant.
- `mul_vld_in`  out  1  to `MUL` `vld_in`.
- `mul_info_in`  out  23  to `MUL` `info_in`, as {id, user}.
- `mul_data0`  out  16  to `MUL` `data0`.
- `mul_data1`  out  16  to `MUL` `data1`.
- `mul_vld_out`  in  1  from `MUL` `vld_out`.
- `mul_info_out`  in  24  from `MUL` `info_out`.
- `mul_result`  in  16  from `MUL` `mul`.
- `rsp_vld`  out  `NREQ`  one-hot product valid. No backpressure.
- `rsp_info`  out  `USER_W`  returned user tag.
- `rsp_data`  out  16  FP16 product.
- `busy`  out  1  high when any op is in flight or a burst is locked.

## Operation
FSM states:
- **IDLE**: round-robin among `req_vld`, starting at pointer `ptr`. The winner w gets `req_rdy[w]=1`.
  - Accept with `req_last[w]=1`: `ptr←w+1` (mod `NREQ`), stay in IDLE.
  - Accept with `req_last[w]=0`: `owner←w`, go to LOCK.
- **LOCK**: only `owner` is eligible, with `req_rdy[owner]=req_vld[owner]`.
  - Owner deasserting `req_vld` produces a bubble. Other requesters are not granted.
  - Accept with `req_last=1`: `ptr←owner+1`, go to IDLE.

Issue register:
- On accept, register `mul_vld_in=1`, `mul_info_in={w[IDW-1:0], req_info[w]}` and the operands.
- With no accept, `mul_vld_in=0` and the operand/info registers hold.

Response:
- When `mul_vld_out=1`, decode `id=mul_info_out[22:USER_W]`. Ignore bit 23 (zero-extension).
- Register `rsp_vld=1<<id`, `rsp_info=mul_info_out[USER_W-1:0]`, `rsp_data=mul_result`.
- Otherwise `rsp_vld=0` and data/info hold.

In-flight counter `cnt` (0..3):
- +1 on accept, −1 on `mul_vld_out`. Both in the same cycle: unchanged.
- `busy = (cnt≠0) | (state==LOCK)`.

Data handling:
- Operands pass through unmodified. No FP arithmetic here.
- NaN, Inf and subnormal handling is `FLOAT16_MUL`'s.

## Timing
- Reset values: `req_rdy`=0, `mul_vld_in`=0, `mul_info_in`=0, `mul_data0/1`=0, `rsp_vld`=0, `rsp_info`=0, `rsp_data`=0, `busy`=0, `ptr`=0, state IDLE, `cnt`=0.
- Throughput: 1 op/cycle sustained, including across a burst-to-next-grant boundary.
- Latency: accept at edge N, then `mul_vld_in` high in cycle N+1, `mul_vld_out` in N+2, `rsp_vld` in N+3. Fixed at 3 cycles; results return in issue order.
- `req_rdy` depends only on registered state plus the current `req_vld`. There is no path from `req_data`/`req_info`.
- A requester may drop `req_vld` without acceptance. The arbiter holds no obligation.
- Reset mid-operation discards in-flight ops and releases any burst lock. No response is produced for discarded ops. `MUL`'s unreset `mul` register is masked by `vld_out=0`.

## Structure
- Shared package `xf_pkg`:
  - `FP16_W`=16.
  - `MUL_INFO_IN_W`=23.
  - `MUL_INFO_OUT_W`=24.
  - The `{id,user}` field-position constants.
- Sub-module `rr_pick`: combinational round-robin first-set-from-pointer over an `NREQ` request vector. Outputs one-hot grant plus index.
- `MUL` is instantiated by the parent, not inside `mul_arb`. The bench wires both together.

## Test plan
- **Single op:** `req_vld[2]=1`, `last=1`, operands 0x4000 × 0x4200 (2.0×3.0), info 0x1ABCD. Expect `req_rdy[2]` in the same cycle, then `rsp_vld=0100`, `rsp_data=0x4600`, `rsp_info=0x1ABCD` exactly 3 cycles after accept, and `ptr=3`.
- **Fairness:** all 4 requesters hold valid with `last=1` for 8 cycles. Expect grant order 0,1,2,3,0,1,2,3, eight responses in the same order, and no idle cycles.
- **Burst lock:** requester 1 sends 3 beats (`last`=0,0,1) while 0 and 3 are valid. Expect grants 1,1,1, then 3, then 0. A bubble inserted mid-burst (req1 valid low for 1 cycle) yields a 1-cycle gap with no other grant.
- **ID routing:** alternate requesters 3 and 0 back-to-back. Expect `rsp_vld` 1000, 0001, … aligned with the issue order, with `rsp_info` matching each op.
- **Reset mid-flight:** 2 ops in flight plus a burst locked to requester 2, then assert `rst_n=0` for 1 cycle. Expect all outputs 0, no stale `rsp_vld`, and after release requester 0 granted first with `busy=0` until the next accept.
- **busy/cnt:** a single op gives `busy` high from the accept edge to the `mul_vld_out` cycle, then 0. An accept and a return in the same cycle keep `cnt` unchanged.
